// File: rtl/fetch_decode.sv
// Fetch and decode stage of the sequential Y86-64 core. Field extraction is
// combinational. The 15-entry register file is the only clocked state here.
module fetch_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC,
  input  logic [0:79] instruct,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic        mem_err,
  output logic        instruct_err
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] r_regs [0:14];
  logic [7:0]  w_bytes [0:9];
  logic        w_need_regids;
  logic        w_need_valc;
  logic [63:0] w_valc_raw;
  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;

  // Byte n of the window sits at instruct[8n:8n+7], most significant bit first.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      w_bytes[i] = instruct[8*i +: 8];
    end
  end

  assign icode = w_bytes[0][7:4];
  assign ifun  = w_bytes[0][3:0];

  always_comb begin
    w_need_regids = 1'b0;
    w_need_valc   = 1'b0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: w_need_regids = 1'b1;
      4'h3, 4'h4, 4'h5:       begin w_need_regids = 1'b1; w_need_valc = 1'b1; end
      4'h7, 4'h8:             w_need_valc = 1'b1;
      default:                ;
    endcase
  end

  assign ra = w_need_regids ? w_bytes[1][7:4] : RNONE;
  assign rb = w_need_regids ? w_bytes[1][3:0] : RNONE;

  // The constant is little-endian and follows the register byte when present.
  always_comb begin
    w_valc_raw = '0;
    for (int k = 0; k < 8; k++) begin
      w_valc_raw[8*k +: 8] = w_need_regids ? w_bytes[k+2] : w_bytes[k+1];
    end
  end

  assign valC = w_need_valc ? w_valc_raw : 64'd0;
  assign valP = PC + 64'd1 + {63'd0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);

  assign mem_err = (PC > 64'd1023);

  always_comb begin
    instruct_err = 1'b0;
    case (icode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
      4'h8, 4'h9, 4'hA, 4'hB: instruct_err = (ifun != 4'h0);
      4'h2, 4'h7:             instruct_err = (ifun > 4'h6);
      4'h6:                   instruct_err = (ifun > 4'h3);
      default:                instruct_err = 1'b1;
    endcase
  end

  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    case (icode)
      4'h2:       w_src_a = ra;
      4'h4, 4'h6: begin w_src_a = ra; w_src_b = rb; end
      4'h5:       w_src_b = rb;
      4'h8:       w_src_b = RRSP;
      4'h9, 4'hB: begin w_src_a = RRSP; w_src_b = RRSP; end
      4'hA:       begin w_src_a = ra; w_src_b = RRSP; end
      default:    ;
    endcase
  end

  assign valA = (w_src_a == RNONE) ? 64'd0 : r_regs[w_src_a];
  assign valB = (w_src_b == RNONE) ? 64'd0 : r_regs[w_src_b];

  // The M port is written last so it takes priority when both ports target one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 64'(i);
      end
    end else begin
      if (dstE != RNONE) r_regs[dstE] <= valE;
      if (dstM != RNONE) r_regs[dstM] <= valM;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed steps followed by randomized instructions and
// register writes, checked against a behavioural model of the stage.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] PC;
  logic [0:79] instruct;
  logic [3:0]  dstE, dstM;
  logic [63:0] valE, valM;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valC, valP, valA, valB;
  logic        mem_err, instruct_err;

  int total = 0;
  int bad = 0;

  logic [7:0]  b [0:9];
  logic [63:0] m_reg [0:14];

  fetch_decode dut (
    .clk(clk), .rst(rst), .PC(PC), .instruct(instruct),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .icode(icode), .ifun(ifun), .ra(ra), .rb(rb),
    .valC(valC), .valP(valP), .valA(valA), .valB(valB),
    .mem_err(mem_err), .instruct_err(instruct_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic clear_bytes();
    for (int i = 0; i < 10; i++) b[i] = 8'h00;
  endtask

  // Drive PC and the byte window between clock edges and let outputs settle.
  task automatic apply(input logic [63:0] pc);
    @(negedge clk);
    PC = pc;
    for (int i = 0; i < 10; i++) instruct[8*i +: 8] = b[i];
    #1;
  endtask

  task automatic clock_write(input logic r, input logic [3:0] de, input logic [63:0] ve,
                             input logic [3:0] dm, input logic [63:0] vm);
    @(negedge clk);
    rst = r; dstE = de; valE = ve; dstM = dm; valM = vm;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 15; i++) m_reg[i] = 64'(i);
    end else begin
      if (de != 4'hF) m_reg[de] = ve;
      if (dm != 4'hF) m_reg[dm] = vm;
    end
    #1;
    rst = 1'b0; dstE = 4'hF; dstM = 4'hF;
  endtask

  function automatic logic [63:0] rd(input logic [3:0] s);
    return (s == 4'hF) ? 64'd0 : m_reg[s];
  endfunction

  // Expected outputs derived from the instruction-set rules and the model registers.
  task automatic check_model(input string tag);
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb, e_sa, e_sb;
    logic        nr, nv, e_ierr;
    logic [63:0] e_valc;
    int          start;
    e_icode = b[0][7:4];
    e_ifun  = b[0][3:0];
    nr = e_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    nv = e_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    e_ra = nr ? b[1][7:4] : 4'hF;
    e_rb = nr ? b[1][3:0] : 4'hF;
    start = nr ? 2 : 1;
    e_valc = 64'd0;
    if (nv) for (int k = 0; k < 8; k++) e_valc = e_valc + (64'(b[start+k]) << (8*k));
    e_ierr = (e_icode > 4'hB)
          || ((e_icode inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) && e_ifun != 0)
          || ((e_icode inside {4'h2, 4'h7}) && e_ifun > 6)
          || (e_icode == 4'h6 && e_ifun > 3);
    e_sa = (e_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? e_ra : (e_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    e_sb = (e_icode inside {4'h4, 4'h5, 4'h6}) ? e_rb : (e_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    chk(tag, "icode", 64'(icode), 64'(e_icode));
    chk(tag, "ifun",  64'(ifun),  64'(e_ifun));
    chk(tag, "ra",    64'(ra),    64'(e_ra));
    chk(tag, "rb",    64'(rb),    64'(e_rb));
    chk(tag, "valC",  valC, e_valc);
    chk(tag, "valP",  valP, PC + 64'd1 + (nr ? 64'd1 : 64'd0) + (nv ? 64'd8 : 64'd0));
    chk(tag, "valA",  valA, rd(e_sa));
    chk(tag, "valB",  valB, rd(e_sb));
    chk(tag, "mem_err", 64'(mem_err), 64'(PC > 64'd1023));
    chk(tag, "instruct_err", 64'(instruct_err), 64'(e_ierr));
  endtask

  initial begin
    rst = 1'b1; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    PC = '0; instruct = '0;
    for (int i = 0; i < 15; i++) m_reg[i] = 64'hx;
    clock_write(1'b1, 4'hF, 64'd0, 4'hF, 64'd0);

    // Reset contents read back through OPq operand ports.
    for (int i = 0; i < 15; i++) begin
      clear_bytes(); b[0] = 8'h60; b[1] = {4'(i), 4'(14 - i)};
      apply(64'd0);
      chk("reset_rd", "valA", valA, 64'(i));
      chk("reset_rd", "valB", valB, 64'(14 - i));
    end

    clear_bytes(); b[0] = 8'h20; b[1] = 8'h34;
    apply(64'd64);
    chk("cmov", "ra", 64'(ra), 64'd3);
    chk("cmov", "valA", valA, 64'd3);
    chk("cmov", "valB", valB, 64'd0);
    chk("cmov", "valP", valP, 64'd66);
    check_model("cmov");

    clear_bytes(); b[0] = 8'h61; b[1] = 8'h23;
    apply(64'd62);
    chk("opq", "ifun", 64'(ifun), 64'd1);
    chk("opq", "valA", valA, 64'd2);
    chk("opq", "valB", valB, 64'd3);
    chk("opq", "valP", valP, 64'd64);
    check_model("opq");

    clear_bytes();
    b[0] = 8'h70; b[1] = 8'h34; b[2] = 8'h61; b[3] = 8'h23; b[4] = 8'h20;
    b[5] = 8'h34; b[6] = 8'h25; b[7] = 8'h53; b[8] = 8'h00;
    apply(64'd60);
    chk("jxx", "valC", valC, 64'h0053253420236134);
    chk("jxx", "valP", valP, 64'd69);
    chk("jxx", "ra", 64'(ra), 64'hF);
    check_model("jxx");

    clear_bytes();
    apply(64'd68);
    chk("halt", "valP", valP, 64'd69);
    chk("halt", "rb", 64'(rb), 64'hF);
    chk("halt", "instruct_err", 64'(instruct_err), 64'd0);
    check_model("halt");

    b[0] = 8'hC0; apply(64'd68);
    chk("bad_icode", "instruct_err", 64'(instruct_err), 64'd1);
    b[0] = 8'h27; apply(64'd68);
    chk("bad_ifun", "instruct_err", 64'(instruct_err), 64'd1);
    b[0] = 8'h00; apply(64'd1023);
    chk("pc1023", "mem_err", 64'(mem_err), 64'd0);
    apply(64'd1024);
    chk("pc1024", "mem_err", 64'(mem_err), 64'd1);

    clear_bytes(); b[0] = 8'hB0; b[1] = 8'h0F;
    apply(64'd100);
    chk("popq", "valA", valA, 64'd4);
    chk("popq", "valB", valB, 64'd4);
    chk("popq", "valP", valP, 64'd102);
    check_model("popq");

    clear_bytes(); b[0] = 8'h30; b[1] = 8'hF1; b[2] = 8'h05;
    apply(64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap", "valP", valP, 64'd9);
    chk("wrap", "valC", valC, 64'd5);

    clock_write(1'b0, 4'd3, 64'hDEAD, 4'd3, 64'hBEEF);
    clear_bytes(); b[0] = 8'h60; b[1] = 8'h3F;
    apply(64'd0);
    chk("wr_prio", "valA", valA, 64'hBEEF);
    clock_write(1'b1, 4'd3, 64'h1111, 4'd3, 64'h2222);
    apply(64'd0);
    chk("rst_ovr", "valA", valA, 64'd3);
    clock_write(1'b0, 4'd5, 64'h1234, 4'd6, 64'h5678);
    clear_bytes(); b[0] = 8'h60; b[1] = 8'h56;
    apply(64'd0);
    chk("two_ports", "valA", valA, 64'h1234);
    chk("two_ports", "valB", valB, 64'h5678);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 1)
        clock_write($urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                    4'($urandom_range(0, 15)), {$urandom, $urandom});
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b[0][7:4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 1) b[0][3:0] = 4'd0;
      if ($urandom_range(0, 7) == 0) apply({$urandom, $urandom});
      else apply(64'($urandom_range(0, 1100)));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Combined fetch and decode stage of the sequential Y86-64 processor. It takes the current PC and a 10-byte instruction window, splits out the instruction fields, and computes the constant word and the fall-through PC. It reads operands valA/valB from the 15-entry register file, which it owns. It sits between the PC-select logic and the execute stage; the register-file write port is driven by the write-back stage.

## Interface
- No parameters.
- clk  in  1  single clock; only the register file is clocked
- rst  in  1  reset, synchronous, active-high
- PC  in  64  address of the current instruction
- instruct  in  [0:79]  instruction bytes; instruct[0:7] is byte at PC, instruct[8:15] is byte at PC+1, … up to byte PC+9
- dstE  in  4  write-back E destination register (4'hF = none)
- valE  in  64  data for dstE
- dstM  in  4  write-back M destination register (4'hF = none)
- valM  in  64  data for dstM
- icode  out  4  byte0[7:4]
- ifun  out  4  byte0[3:0]
- ra  out  4  register A field
- rb  out  4  register B field
- valC  out  64  constant word
- valP  out  64  fall-through PC
- valA  out  64  operand A
- valB  out  64  operand B
- mem_err  out  1  instruction address out of range
- instruct_err  out  1  invalid icode/ifun

## Operation
- **Opcodes:** 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- **need_regids** is set for icode ∈ {2,3,4,5,6,A,B}.
  - When set: ra = byte1[7:4], rb = byte1[3:0].
  - Otherwise: ra = rb = 4'hF.
- **need_valC** is set for icode ∈ {3,4,5,7,8}.
  - valC is 8 bytes, little-endian, starting at byte 2 if need_regids, else byte 1.
  - When need_valC is clear, valC = 0.
- **valP** = PC + 1 + need_regids + 8·need_valC, using 64-bit unsigned wrap-around.
- **instruct_err** = 1 under any of these conditions:
  - icode > 4'hB
  - ifun ≠ 0 for icode ∈ {0,1,3,4,5,8,9,A,B}
  - ifun > 6 for icode 2 or 7
  - ifun > 3 for icode 6
- **mem_err** = 1 when PC > 1023 (instruction memory is 1024 bytes).
  - Field outputs are still computed from instruct as given; downstream logic handles the status.
- **srcA:**
  - rA for icode ∈ {2,4,6,A}
  - 4 (%rsp) for icode ∈ {9,B}
  - else F
- **srcB:**
  - rB for icode ∈ {4,5,6}
  - 4 for icode ∈ {8,9,A,B}
  - else F
- **Operand reads:** valA = R[srcA] and valB = R[srcB]; a source of F reads 0.
- **Register file:** R[0..14], 64-bit each.
  - On rising clk with rst=0: if dstE ≠ F, R[dstE] ← valE; if dstM ≠ F, R[dstM] ← valM.
  - dstE = dstM ≠ F: valM wins.
  - Index F is never stored.

## Timing
- Fetch and decode are purely combinational from PC, instruct, and the register state; outputs settle within the same cycle.
- Register reads are asynchronous; writes take effect at the rising clk edge.
  - A value written at edge k is visible on valA/valB immediately after edge k; there is no bypass within the cycle.
- **Reset:** at a rising clk with rst=1, R[i] ← i for i = 0..14 (e.g. R[3]=3, R[4]=4).
  - rst overrides any simultaneous write.
  - Combinational outputs have no reset value; they follow their inputs.
- Reset asserted mid-operation clears register contents at that edge only; fetch fields are unaffected.

## Test plan
- Reset, then PC=64, bytes 20 34 → icode=2, ifun=0, ra=3, rb=4, valA=3, valB=0, valC=0, valP=66, both error flags 0.
- PC=62, bytes 61 23 → icode=6, ifun=1, ra=2, rb=3, valA=2, valB=3, valP=64.
- PC=60, bytes 70 34 61 23 20 34 25 53 00 → icode=7, ra=rb=F, valC=0x0053253420236134, valP=69, valA=valB=0.
- PC=68, byte 00 → halt: ra=rb=F, valP=69.
  - Byte C0 → instruct_err=1.
  - Byte 27 → instruct_err=1.
  - PC=1024 → mem_err=1.
- Byte B0 with R[4]=4 → srcA=srcB=4, valA=valB=4, valP=PC+2.
- Write dstE=3, valE=0xDEAD, dstM=3, valM=0xBEEF → R[3]=0xBEEF after edge.
  - Then assert rst with a simultaneous write → R[3]=3.
